// File: rtl/byte_frame_tx.sv
// Frame transmitter: a DEPTH-byte buffer loaded through a random-access write
// port and streamed out one byte per accepted valid/ready beat.
module byte_frame_tx #(
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic [AW-1:0] frame_len,
  input  logic          tx_ready,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_first,
  output logic          tx_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH);

  state_t        state_r, state_s;
  logic [7:0]    buf_r [DEPTH];
  logic [AW-1:0] idx_r, idx_s;
  logic [AW-1:0] len_r, len_s;
  logic          done_r, done_s;
  logic          wr_ok_s;
  logic          last_s;
  logic [7:0]    rd_data_s;

  // The buffer is frozen while sending so the transmitted frame cannot tear.
  assign wr_ok_s = wr_en && (wr_addr < DEPTH_L) && (state_r == IDLE);
  assign last_s  = (idx_r == (len_r - AW'(1)));

  // Frame buffer storage with synchronous clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        buf_r[i] <= 8'h00;
      end else if (wr_ok_s && (wr_addr == AW'(i))) begin
        buf_r[i] <= wr_data;
      end
    end
  end

  // Read mux selecting the byte at the current index.
  always_comb begin
    rd_data_s = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx_r == AW'(i)) begin
        rd_data_s = buf_r[i];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  // Next-state logic for the IDLE/SEND sequencer.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    len_s   = len_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SEND;
          idx_s   = '0;
          // A zero or oversize request means "the whole buffer".
          if ((frame_len == '0) || (frame_len > DEPTH_L)) begin
            len_s = DEPTH_L;
          end else begin
            len_s = frame_len;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (last_s) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            idx_s = idx_r + AW'(1);
          end
        end else begin
          idx_s = idx_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state, index, latched length and done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= '0;
      len_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      len_r   <= len_s;
      done_r  <= done_s;
    end
  end

  assign tx_valid = (state_r == SEND);
  assign busy     = (state_r == SEND);
  assign tx_data  = tx_valid ? rd_data_s : 8'h00;
  assign tx_first = tx_valid && (idx_r == '0);
  assign tx_last  = tx_valid && last_s;
  assign done     = done_r;

endmodule

// File: tb/tb_byte_frame_tx.sv
// Scoreboard bench for byte_frame_tx: a frame-level model queues expected
// beats, and a monitor compares them against every presented byte.
module tb_byte_frame_tx;

  localparam int DEPTH = 10;
  localparam int AW    = 4;

  typedef struct {
    logic [7:0] d;
    bit         f;
    bit         l;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = 8'h00;
  logic          start = 1'b0;
  logic [AW-1:0] frame_len = '0;
  logic          tx_ready = 1'b0;
  logic          tx_valid, tx_first, tx_last, busy, done;
  logic [7:0]    tx_data;

  int    vectors = 0;
  int    errors = 0;
  beat_t exp_q[$];
  bit    pending_done = 1'b0;
  bit    mon_en = 1'b0;
  logic [7:0] mbuf [DEPTH];

  byte_frame_tx #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .frame_len(frame_len),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_first(tx_first), .tx_last(tx_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare presented beats and done pulses against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pending_done) begin
        check("done_pulse", {31'd0, done}, 32'd1);
        pending_done = 1'b0;
      end else if (done) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end
      if (tx_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {31'd0, tx_valid}, 32'd0);
        end else begin
          check("tx_data", {24'd0, tx_data}, {24'd0, exp_q[0].d});
          check("tx_first", {31'd0, tx_first}, {31'd0, exp_q[0].f});
          check("tx_last", {31'd0, tx_last}, {31'd0, exp_q[0].l});
          if (tx_ready) begin
            pending_done = exp_q[0].l;
            void'(exp_q.pop_front());
          end
        end
      end else if (tx_first || tx_last) begin
        check("markers_idle", {30'd0, tx_first, tx_last}, 32'd0);
      end
    end
  end

  task automatic idle_write(input logic [AW-1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    if (a < DEPTH) mbuf[a] = d;
    cyc();
    wr_en = 1'b0;
  endtask

  // junk: 0 none, 1 write slot3=0x55 plus start at beat 1, 2 random writes/starts.
  task automatic run_frame(input logic [AW-1:0] flen, input int ready_pct,
                           input int stall_at, input int stall_n,
                           input bit sc_wr, input logic [AW-1:0] sc_addr,
                           input logic [7:0] sc_data, input int junk,
                           output int busy_cycles);
    int n;
    n = (flen == 0 || flen > DEPTH) ? DEPTH : int'(flen);
    start = 1'b1; frame_len = flen;
    wr_en = sc_wr; wr_addr = sc_addr; wr_data = sc_data;
    if (sc_wr && sc_addr < DEPTH) mbuf[sc_addr] = sc_data;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d = mbuf[i]; b.f = (i == 0); b.l = (i == n - 1);
      exp_q.push_back(b);
    end
    cyc();
    start = 1'b0; wr_en = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 300) begin
      if (busy_cycles >= stall_at && busy_cycles < stall_at + stall_n)
        tx_ready = 1'b0;
      else
        tx_ready = ($urandom_range(99) < ready_pct);
      if (junk == 1) begin
        wr_en = (busy_cycles == 1); wr_addr = 4'd3; wr_data = 8'h55;
        start = (busy_cycles == 1);
      end else if (junk == 2) begin
        wr_en = $urandom_range(1); wr_addr = AW'($urandom_range(15));
        wr_data = 8'($urandom); start = $urandom_range(1);
      end
      cyc();
      busy_cycles++;
    end
    wr_en = 1'b0; start = 1'b0;
    if (busy_cycles >= 300) check("frame_timeout", 32'(busy_cycles), 32'd0);
  endtask

  initial begin
    int bc;
    for (int i = 0; i < DEPTH; i++) mbuf[i] = 8'h00;
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_first", {31'd0, tx_first}, 32'd0);
    check("rst_tx_last", {31'd0, tx_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    mon_en = 1'b1;
    run_frame(4'd3, 100, 0, 0, 1'b0, 4'd0, 8'h00, 0, bc);

    for (int i = 0; i < DEPTH; i++) idle_write(AW'(i), 8'hA0 + 8'(i));
    run_frame(4'd0, 100, 0, 0, 1'b0, 4'd0, 8'h00, 0, bc);
    check("busy_cycles_full", 32'(bc), 32'd10);

    run_frame(4'd4, 100, 2, 3, 1'b0, 4'd0, 8'h00, 0, bc);
    check("busy_cycles_stall", 32'(bc), 32'd7);

    run_frame(4'd5, 100, 0, 0, 1'b0, 4'd0, 8'h00, 1, bc);
    run_frame(4'd5, 100, 0, 0, 1'b0, 4'd0, 8'h00, 0, bc);

    run_frame(4'd1, 100, 0, 0, 1'b1, 4'd0, 8'h7E, 0, bc);
    idle_write(4'd12, 8'hEE);
    run_frame(4'd10, 100, 0, 0, 1'b0, 4'd0, 8'h00, 0, bc);

    // Abort a len-10 frame at index 5.
    start = 1'b1; frame_len = 4'd10; tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      beat_t b;
      b.d = mbuf[i]; b.f = (i == 0); b.l = (i == DEPTH - 1);
      exp_q.push_back(b);
    end
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    reset = 1'b1; tx_ready = 1'b0;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    pending_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) mbuf[i] = 8'h00;
    check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    cyc();
    run_frame(4'd2, 100, 0, 0, 1'b0, 4'd0, 8'h00, 0, bc);

    for (int f = 0; f < 40; f++) begin
      int nw;
      nw = $urandom_range(4);
      for (int w = 0; w < nw; w++)
        idle_write(AW'($urandom_range(15)), 8'($urandom));
      run_frame(AW'($urandom_range(15)), 30 + $urandom_range(70), 0, 0,
                1'($urandom_range(1)), AW'($urandom_range(15)), 8'($urandom), 2, bc);
    end

    tx_ready = 1'b1;
    cyc(); cyc(); cyc();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/byte_frame_tx.md
Name: byte_frame_tx

Overview:
- Frame transmitter for the byte-stream datapath: holds a frame of up to DEPTH bytes and emits it one byte per accepted beat.
- The frame is loaded through a random-access write port. Transmission runs on a valid/ready byte interface with first/last markers.
- Counterpart to the shift-in byte frame receiver. It sits between the control/load logic and the downstream byte sink or pad outputs.

Parameters:
- DEPTH, 10, number of byte slots in the frame buffer (2..15).
- AW, 4, width of the address and length fields. Must satisfy 2^AW > DEPTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  buffer write strobe
- wr_addr  input  AW  buffer slot to write
- wr_data  input  8  byte to write
- start  input  1  request transmission of the frame (single-cycle pulse or level)
- frame_len  input  AW  number of bytes to send; sampled on an accepted start
- tx_ready  input  1  downstream can accept a byte this cycle
- tx_valid  output  1  tx_data holds a valid byte
- tx_data  output  8  current byte
- tx_first  output  1  current byte is slot 0 of the frame
- tx_last  output  1  current byte is the final byte of the frame
- busy  output  1  frame transmission in progress
- done  output  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (clk edge with reset=1):
  - All buffer bytes are set to 0x00; state is IDLE; index and latched length are 0.
  - Outputs: tx_valid=0, tx_first=0, tx_last=0, busy=0, done=0, tx_data=0x00.
- Buffer write:
  - Occurs on a clk edge when wr_en=1 and wr_addr<DEPTH, with state IDLE.
  - Writes with wr_addr>=DEPTH are dropped silently.
  - Writes while busy=1 are dropped; the frame contents are frozen during transmission.
- States: IDLE, SEND.
- IDLE:
  - start=1 at a clk edge moves the state to SEND, clears index to 0 and latches the length.
  - Latched length = frame_len, except frame_len=0 or frame_len>DEPTH, which is clamped to DEPTH.
  - A write in the same cycle as start is committed, and the new value is the one transmitted.
- SEND:
  - busy=1 and tx_valid=1. tx_data = buf[index], driven combinationally from the frozen buffer and stable while stalled.
  - tx_first = (index==0). tx_last = (index==len-1). Both are 0 whenever tx_valid=0.
  - A beat is transferred on a clk edge where tx_valid=1 and tx_ready=1.
  - Transfer with index<len-1: index increments by 1.
  - Transfer with index==len-1: state returns to IDLE and done=1 for exactly the next cycle.
  - tx_ready=0 holds index, tx_data and all markers unchanged. There is no timeout.
  - start while in SEND is ignored; no queuing.
- Latency and throughput:
  - First byte is valid the cycle after the start edge.
  - With tx_ready held high, a len-N frame occupies exactly N cycles of tx_valid. done follows one cycle after the last beat.
  - Back-to-back frames: a start in the cycle done=1 (state IDLE) is accepted, giving a one-cycle gap between frames.
- len=1: tx_first and tx_last are both 1 on the single beat.
- Reset mid-frame:
  - Transmission aborts and the buffer clears.
  - done is not pulsed, and tx_valid is 0 from the cycle after the reset edge.
- Index and length widths are AW bits; index never exceeds len-1, so there is no wrap-around.

Test Plan:
- Reset state:
  - Assert reset for 2 cycles.
  - Required: all outputs 0. Starting with frame_len=3 and tx_ready=1 then sends 0x00,0x00,0x00.
- Full frame, no backpressure:
  - Write buf[i]=0xA0+i for i=0..9, pulse start with frame_len=0 (clamped to 10), tx_ready=1.
  - Required: 10 consecutive beats 0xA0..0xA9; tx_first only on 0xA0, tx_last only on 0xA9; done pulses exactly one cycle later; busy high for exactly 10 cycles.
- Backpressure:
  - Send with frame_len=4 and tx_ready low for 3 cycles at index 2.
  - Required: tx_data holds 0xA2 with tx_valid=1 throughout the stall; sequence 0xA0,0xA1,0xA2,0xA3 with no duplicates or drops.
- Writes and starts while busy:
  - During a len-5 frame, write wr_addr=3, wr_data=0x55 at index 1, and pulse start again.
  - Required: slot 3 is sent as 0xA3, and exactly one done occurs. A following frame also sends 0xA3 at slot 3.
- Write on the start cycle, and out-of-range address:
  - In IDLE, write addr 0 = 0x7E in the start cycle with frame_len=1.
  - Required: a single beat 0x7E with tx_first=tx_last=1.
  - A write to addr 12 changes no slot.
- Reset mid-frame:
  - Assert reset at index 5 of a len-10 frame.
  - Required: tx_valid=0 and busy=0 the next cycle, no done pulse, and a subsequent len-2 frame sends 0x00,0x00.
